// File: rtl/display_pkg.sv
// Shared types and geometry constants for the 8x8 matrix frame scheduler.
package display_pkg;

  // Frame geometry: 8 rows by 8 columns, bit 8*row+col holds one pixel.
  localparam int FRAME_W = 64;
  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int ROW_W   = $clog2(ROWS);
  localparam int COL_W   = $clog2(COLS);

  // Scheduler states: waiting for a request, holding a captured frame, dwelling.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURED = 2'd1,
    ST_DWELL    = 2'd2
  } sched_state_t;

endpackage

// File: rtl/tick_divider.sv
// Free-running divider producing a one-cycle row-scan enable every SCAN_DIV cycles.
module tick_divider #(
  parameter int SCAN_DIV = 65536
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  // The tick is registered one count early so it is high exactly while the
  // counter holds SCAN_DIV-1.
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(SCAN_DIV - 2);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  // Count 0..SCAN_DIV-1 and wrap; flag the terminal count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
      r_tick <= (r_cnt == CNT_PRE);
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/frame_scheduler.sv
// Two-source frame scheduler: round-robin capture, swap on end-of-scan, and a
// minimum dwell of DWELL_FRAMES completed scans before the next grant.
module frame_scheduler
  import display_pkg::*;
#(
  parameter int SCAN_DIV     = 65536,
  parameter int DWELL_FRAMES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [1:0]         i_req,
  input  logic [FRAME_W-1:0] i_data0,
  input  logic [FRAME_W-1:0] i_data1,
  output logic [1:0]         o_gnt,
  input  logic               i_frame_end,
  output logic               o_scan_tick,
  output logic [FRAME_W-1:0] o_frame,
  output logic               o_active_src,
  output logic               o_swap,
  output logic               o_pending
);

  // Dwell counter holds 0..DWELL_FRAMES-1; keep at least one bit.
  localparam int DW_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam logic [DW_W-1:0] DWELL_LOAD = DW_W'(DWELL_FRAMES - 1);

  sched_state_t       r_state;
  logic [1:0]         r_gnt;
  logic [FRAME_W-1:0] r_frame;
  logic [FRAME_W-1:0] r_pend_data;
  logic               r_active_src;
  logic               r_swap;
  logic               r_pending;
  logic               r_last;
  logic [DW_W-1:0]    r_dwell;

  logic               w_any_req;
  logic               w_win;
  logic [FRAME_W-1:0] w_win_data;

  // Round-robin pick: a lone requester wins, a tie goes to the source that
  // was not granted last.
  assign w_any_req  = |i_req;
  assign w_win      = (i_req == 2'b11) ? ~r_last : i_req[1];
  assign w_win_data = w_win ? i_data1 : i_data0;

  // Scheduler FSM with registered grant, swap, pending and frame outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_gnt        <= 2'b00;
      r_frame      <= '0;
      r_pend_data  <= '0;
      r_active_src <= 1'b0;
      r_swap       <= 1'b0;
      r_pending    <= 1'b0;
      r_last       <= 1'b1;
      r_dwell      <= '0;
    end else begin
      r_gnt  <= 2'b00;
      r_swap <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A coincident end-of-scan is ignored here; the swap waits for the next one.
          if (w_any_req) begin
            r_pend_data <= w_win_data;
            r_last      <= w_win;
            r_gnt       <= w_win ? 2'b10 : 2'b01;
            r_pending   <= 1'b1;
            r_state     <= ST_CAPTURED;
          end
        end
        ST_CAPTURED: begin
          if (i_frame_end) begin
            r_frame      <= r_pend_data;
            r_active_src <= r_last;
            r_swap       <= 1'b1;
            r_dwell      <= DWELL_LOAD;
            r_pending    <= 1'b0;
            r_state      <= (DWELL_LOAD == '0) ? ST_IDLE : ST_DWELL;
          end
        end
        ST_DWELL: begin
          if (i_frame_end) begin
            if (r_dwell == '0) begin
              r_state <= ST_IDLE;
            end else begin
              r_dwell <= r_dwell - DW_W'(1);
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_pending <= 1'b0;
        end
      endcase
    end
  end

  tick_divider #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick_divider (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_tick  (o_scan_tick)
  );

  assign o_gnt        = r_gnt;
  assign o_frame      = r_frame;
  assign o_active_src = r_active_src;
  assign o_swap       = r_swap;
  assign o_pending    = r_pending;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: two instances (dwell 4 and dwell 1).
module tb_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [1:0]  req = 2'b00;
  logic [63:0] data0 = '0;
  logic [63:0] data1 = '0;
  logic        fe = 1'b0;
  logic [1:0]  gnt;
  logic        tick;
  logic [63:0] frame;
  logic        act;
  logic        swap;
  logic        pend;

  logic [1:0]  req_b = 2'b00;
  logic [63:0] data0_b = '0;
  logic [63:0] data1_b = '0;
  logic        fe_b = 1'b0;
  logic [1:0]  gnt_b;
  logic        tick_b;
  logic [63:0] frame_b;
  logic        act_b;
  logic        swap_b;
  logic        pend_b;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [63:0] PAT_A = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] PAT_5 = 64'h5555_5555_5555_5555;
  localparam logic [63:0] PAT_C = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] PAT_D = 64'hDEAD_BEEF_CAFE_F00D;

  always #5 clk = ~clk;

  frame_scheduler #(.SCAN_DIV(4), .DWELL_FRAMES(4)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_data0(data0), .i_data1(data1),
    .o_gnt(gnt), .i_frame_end(fe), .o_scan_tick(tick), .o_frame(frame),
    .o_active_src(act), .o_swap(swap), .o_pending(pend)
  );

  frame_scheduler #(.SCAN_DIV(8), .DWELL_FRAMES(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_b), .i_data0(data0_b), .i_data1(data1_b),
    .o_gnt(gnt_b), .i_frame_end(fe_b), .o_scan_tick(tick_b), .o_frame(frame_b),
    .o_active_src(act_b), .o_swap(swap_b), .o_pending(pend_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fe_pulse();
    fe = 1'b1;
    step();
    fe = 1'b0;
  endtask

  // Reset values while held, then SCAN_TICK phase over the first 12 cycles.
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_vec++; if (gnt !== 2'b00) begin n_err++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    n_vec++; if (frame !== 64'h0) begin n_err++; $display("FAIL reset_frame got=%h exp=0", frame); end
    n_vec++; if ({act, swap, pend, tick} !== 4'b0000) begin n_err++; $display("FAIL reset_flags got=%b exp=0000", {act, swap, pend, tick}); end
    n_vec++; if (frame_b !== 64'h0) begin n_err++; $display("FAIL reset_frame_b got=%h exp=0", frame_b); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_vec++;
      if (tick !== ((k % 4) == 3)) begin
        n_err++; $display("FAIL scan_tick cycle=%0d got=%b exp=%b", k, tick, (k % 4) == 3);
      end
    end
  endtask

  // Both request after reset: source 0 wins.
  task automatic test_priority();
    req = 2'b11; data0 = PAT_A; data1 = PAT_5;
    step();
    n_vec++; if (gnt !== 2'b01) begin n_err++; $display("FAIL prio_gnt got=%b exp=01", gnt); end
    n_vec++; if (pend !== 1'b1) begin n_err++; $display("FAIL prio_pending got=%b exp=1", pend); end
    n_vec++; if (frame !== 64'h0) begin n_err++; $display("FAIL prio_frame got=%h exp=0", frame); end
    req = 2'b00;
    step();
    n_vec++; if (gnt !== 2'b00) begin n_err++; $display("FAIL prio_gnt_once got=%b exp=00", gnt); end
  endtask

  // Swap, four dwell scans with requests ignored, then round-robin to source 1.
  task automatic test_dwell();
    fe_pulse();
    n_vec++; if (frame !== PAT_A) begin n_err++; $display("FAIL dwell_frame got=%h exp=%h", frame, PAT_A); end
    n_vec++; if ({act, swap, pend} !== 3'b010) begin n_err++; $display("FAIL dwell_swap got=%b exp=010", {act, swap, pend}); end
    req = 2'b11;
    step();
    n_vec++; if ({swap, gnt} !== 3'b000) begin n_err++; $display("FAIL dwell_swap_once got=%b exp=000", {swap, gnt}); end
    for (int n = 1; n <= 4; n++) begin
      fe_pulse();
      n_vec++; if (gnt !== 2'b00) begin n_err++; $display("FAIL dwell_nogrant fe=%0d got=%b exp=00", n, gnt); end
    end
    step();
    n_vec++; if (gnt !== 2'b10) begin n_err++; $display("FAIL dwell_rr_gnt got=%b exp=10", gnt); end
    req = 2'b01;
    step();
    step();
    n_vec++; if (gnt !== 2'b00) begin n_err++; $display("FAIL captured_ignore got=%b exp=00", gnt); end
    req = 2'b00;
    fe_pulse();
    n_vec++; if ({frame, act, swap} !== {PAT_5, 1'b1, 1'b1}) begin n_err++; $display("FAIL swap_src1 got=%h/%b/%b exp=%h/1/1", frame, act, swap, PAT_5); end
    for (int n = 0; n < 4; n++) fe_pulse();
    step();
    n_vec++; if (pend !== 1'b0) begin n_err++; $display("FAIL drain_pending got=%b exp=0", pend); end
  endtask

  // Request and end-of-scan together in IDLE: capture only, swap on next FRAME_END.
  task automatic test_same_cycle();
    req = 2'b01; data0 = PAT_C; fe = 1'b1;
    step();
    req = 2'b00; fe = 1'b0;
    n_vec++; if (gnt !== 2'b01) begin n_err++; $display("FAIL same_gnt got=%b exp=01", gnt); end
    n_vec++; if ({frame, swap} !== {PAT_5, 1'b0}) begin n_err++; $display("FAIL same_noswap got=%h/%b exp=%h/0", frame, swap, PAT_5); end
    step();
    fe_pulse();
    n_vec++; if ({frame, act, swap} !== {PAT_C, 1'b0, 1'b1}) begin n_err++; $display("FAIL same_swap got=%h/%b/%b exp=%h/0/1", frame, act, swap, PAT_C); end
    for (int n = 0; n < 4; n++) fe_pulse();
    step();
  endtask

  // Reset while CAPTURED discards the frame; tie afterwards goes to source 0.
  task automatic test_reset_mid();
    req = 2'b10; data1 = PAT_D;
    step();
    req = 2'b00;
    n_vec++; if ({gnt, pend} !== 3'b101) begin n_err++; $display("FAIL mid_capture got=%b exp=101", {gnt, pend}); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if ({frame, pend, swap} !== {64'h0, 1'b0, 1'b0}) begin n_err++; $display("FAIL mid_reset got=%h/%b/%b exp=0/0/0", frame, pend, swap); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fe_pulse();
    n_vec++; if ({frame, swap} !== {64'h0, 1'b0}) begin n_err++; $display("FAIL mid_fe_only got=%h/%b exp=0/0", frame, swap); end
    req = 2'b11;
    step();
    req = 2'b00;
    n_vec++; if (gnt !== 2'b01) begin n_err++; $display("FAIL mid_first_gnt got=%b exp=01", gnt); end
  endtask

  // DWELL_FRAMES=1 with source 1 requesting continuously: grant, swap, grant...
  task automatic test_back_to_back();
    logic [63:0] pats [3];
    pats[0] = PAT_A; pats[1] = PAT_C; pats[2] = PAT_D;
    req_b = 2'b10; data1_b = pats[0];
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if ({gnt_b, pend_b, swap_b} !== 4'b1010) begin n_err++; $display("FAIL b2b_gnt i=%0d got=%b exp=1010", i, {gnt_b, pend_b, swap_b}); end
      data1_b = pats[(i + 1) % 3];
      fe_b = 1'b1;
      step();
      fe_b = 1'b0;
      n_vec++; if ({frame_b, act_b, swap_b, pend_b, gnt_b} !== {pats[i], 1'b1, 1'b1, 1'b0, 2'b00}) begin
        n_err++; $display("FAIL b2b_swap i=%0d got=%h/%b/%b/%b/%b exp=%h/1/1/0/00", i, frame_b, act_b, swap_b, pend_b, gnt_b, pats[i]);
      end
    end
    req_b = 2'b00;
    step();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_dwell();
    test_same_cycle();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
